// File: rtl/split_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package  : split_bus_pkg
// Shared types and constants for the split-transaction bus arbiter.
// Revision : 1.0
// ============================================================================
package split_bus_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        OWNED        = 2'd1,
        SPLIT_RETURN = 2'd2
    } arb_state_e;

    localparam int SPLIT_TIMEOUT_DEFAULT = 1024;

    // Initiator id width; never below one bit so single-bit ports stay legal.
    function automatic int INIT_ID_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Combinational round-robin select: first set request at or above ptr, wrapping.
// Revision : 1.0
// ============================================================================
module rr_picker
    import split_bus_pkg::*;
#(
    parameter int NUM_INIT = 2
) (
    input  logic [NUM_INIT-1:0]            req,
    input  logic [INIT_ID_W(NUM_INIT)-1:0] ptr,
    output logic [NUM_INIT-1:0]            onehot,
    output logic [INIT_ID_W(NUM_INIT)-1:0] idx
);

    localparam int ID_W = INIT_ID_W(NUM_INIT);

    int w_pos;

    // Walk from the farthest candidate back to ptr so the nearest hit wins.
    always_comb begin
        w_pos  = 0;
        idx    = '0;
        onehot = '0;
        for (int k = NUM_INIT - 1; k >= 0; k--) begin
            w_pos = (int'(ptr) + k) % NUM_INIT;
            if (req[ID_W'(w_pos)]) begin
                idx = ID_W'(w_pos);
            end
        end
        if (|req) begin
            onehot = NUM_INIT'(1) << idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/split_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : split_bus_arbiter
// Round-robin bus arbiter with single outstanding split transaction.
// Optional split abandonment timer enabled by macro SPLIT_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module split_bus_arbiter
    import split_bus_pkg::*;
#(
    parameter int NUM_INIT      = 2,
    parameter int SPLIT_TIMEOUT = SPLIT_TIMEOUT_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_INIT-1:0]             init_req,
    output logic [NUM_INIT-1:0]             init_grant,
    input  logic                            split_ack,
    input  logic                            split_req,
    output logic                            split_grant,
    output logic [INIT_ID_W(NUM_INIT)-1:0]  split_owner,
    output logic                            split_pending,
    output logic                            bus_busy,
    output logic                            split_err
);

    localparam int              ID_W    = INIT_ID_W(NUM_INIT);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_INIT - 1);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       owner_q, owner_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       split_owner_q, split_owner_d;
    logic [NUM_INIT-1:0]   grant_q, grant_d;
    logic                  split_grant_q, split_grant_d;
    logic                  split_pending_q, split_pending_d;
    logic                  bus_busy_q, bus_busy_d;
    logic                  split_err_q, split_err_d;
    logic                  split_req_prev_q;

    logic [NUM_INIT-1:0]   w_sowner_onehot;
    logic [NUM_INIT-1:0]   w_eligible;
    logic [NUM_INIT-1:0]   w_pick_onehot;
    logic [ID_W-1:0]       w_pick_idx;
    logic [ID_W-1:0]       w_next_ptr;
    logic                  w_expire;

    // The suspended initiator stays masked even while it keeps requesting.
    assign w_sowner_onehot = NUM_INIT'(1) << split_owner_q;
    assign w_eligible      = init_req & ~(split_pending_q ? w_sowner_onehot : '0);
    assign w_next_ptr      = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;

    rr_picker #(
        .NUM_INIT (NUM_INIT)
    ) u_picker (
        .req    (w_eligible),
        .ptr    (rr_ptr_q),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx)
    );

`ifdef SPLIT_TIMEOUT_EN
    localparam int TMR_W = $clog2(SPLIT_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SPLIT_TIMEOUT - 1);

    logic [TMR_W-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (!split_pending_q) begin
            timer_d = '0;
        end else if (timer_q != TMR_LAST) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // A return starting this very cycle beats abandonment.
    assign w_expire = split_pending_q && (timer_q == TMR_LAST)
                    && (state_q != SPLIT_RETURN)
                    && !((state_q == IDLE) && split_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^SPLIT_TIMEOUT;
    assign w_expire       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            owner_q          <= '0;
            rr_ptr_q         <= '0;
            split_owner_q    <= '0;
            grant_q          <= '0;
            split_grant_q    <= 1'b0;
            split_pending_q  <= 1'b0;
            bus_busy_q       <= 1'b0;
            split_err_q      <= 1'b0;
            split_req_prev_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            rr_ptr_q         <= rr_ptr_d;
            split_owner_q    <= split_owner_d;
            grant_q          <= grant_d;
            split_grant_q    <= split_grant_d;
            split_pending_q  <= split_pending_d;
            bus_busy_q       <= bus_busy_d;
            split_err_q      <= split_err_d;
            split_req_prev_q <= split_req;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (split_pending_q && split_req) begin
                    state_d = SPLIT_RETURN;
                end else if (|w_eligible) begin
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (split_ack || !init_req[owner_q]) begin
                    state_d = IDLE;
                end
            end
            SPLIT_RETURN: begin
                if (!split_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d         = owner_q;
        rr_ptr_d        = rr_ptr_q;
        split_owner_d   = split_owner_q;
        split_pending_d = split_pending_q;
        grant_d         = grant_q;
        split_grant_d   = split_grant_q;
        split_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (split_pending_q && split_req) begin
                    grant_d       = w_sowner_onehot;
                    split_grant_d = 1'b1;
                end else if (|w_eligible) begin
                    grant_d = w_pick_onehot;
                    owner_d = w_pick_idx;
                end
            end
            OWNED: begin
                // split_ack outranks a simultaneous request drop.
                if (split_ack) begin
                    grant_d  = '0;
                    rr_ptr_d = w_next_ptr;
                    if (split_pending_q) begin
                        split_err_d = 1'b1;
                    end else begin
                        split_pending_d = 1'b1;
                        split_owner_d   = owner_q;
                    end
                end else if (!init_req[owner_q]) begin
                    grant_d  = '0;
                    rr_ptr_d = w_next_ptr;
                end
            end
            SPLIT_RETURN: begin
                if (!split_req) begin
                    grant_d         = '0;
                    split_grant_d   = 1'b0;
                    split_pending_d = 1'b0;
                end
            end
            default: begin
                grant_d       = '0;
                split_grant_d = 1'b0;
            end
        endcase
        if (split_req && !split_req_prev_q && !split_pending_q) begin
            split_err_d = 1'b1;
        end
        if (w_expire) begin
            split_pending_d = 1'b0;
            split_err_d     = 1'b1;
        end
    end

    assign bus_busy_d = (|grant_d) | split_grant_d;

    assign init_grant    = grant_q;
    assign split_grant   = split_grant_q;
    assign split_owner   = split_owner_q;
    assign split_pending = split_pending_q;
    assign bus_busy      = bus_busy_q;
    assign split_err     = split_err_q;

endmodule
`default_nettype wire

// File: tb/tb_split_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_split_bus_arbiter
// Directed plus randomized bench with a cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_split_bus_arbiter;
    import split_bus_pkg::*;

    localparam int N   = 2;
    localparam int IDW = INIT_ID_W(N);
`ifdef SPLIT_TIMEOUT_EN
    localparam int TO    = 16;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 1024;
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic [N-1:0]   init_req  = '0;
    logic           split_ack = 1'b0;
    logic           split_req = 1'b0;
    logic [N-1:0]   init_grant;
    logic           split_grant;
    logic [IDW-1:0] split_owner;
    logic           split_pending;
    logic           bus_busy;
    logic           split_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    split_bus_arbiter #(
        .NUM_INIT      (N),
        .SPLIT_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_req      (init_req),
        .init_grant    (init_grant),
        .split_ack     (split_ack),
        .split_req     (split_req),
        .split_grant   (split_grant),
        .split_owner   (split_owner),
        .split_pending (split_pending),
        .bus_busy      (bus_busy),
        .split_err     (split_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who holds the bus, whether a split is parked, and for whom.
    int m_owner = -1;
    bit m_ret   = 1'b0;
    bit m_pend  = 1'b0;
    bit m_err   = 1'b0;
    bit m_prev  = 1'b0;
    int m_sown  = 0;
    int m_ptr   = 0;
    int m_age   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ret   = 1'b0;
            m_pend  = 1'b0;
            m_err   = 1'b0;
            m_prev  = 1'b0;
            m_sown  = 0;
            m_ptr   = 0;
            m_age   = 0;
        end else begin
            bit was_pend;
            bit was_idle;
            bit expire;
            int cand;
            was_pend = m_pend;
            was_idle = (m_owner < 0) && !m_ret;
            m_err    = split_req && !m_prev && !was_pend;
            expire   = TO_EN && was_pend && (m_age + 1 >= TO) && !m_ret
                       && !(was_idle && split_req);
            if (m_ret) begin
                if (!split_req) begin
                    m_ret  = 1'b0;
                    m_pend = 1'b0;
                end
            end else if (m_owner >= 0) begin
                if (split_ack) begin
                    if (was_pend) begin
                        m_err = 1'b1;
                    end else begin
                        m_pend = 1'b1;
                        m_sown = m_owner;
                    end
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end else if (!init_req[m_owner]) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end else if (was_pend && split_req) begin
                m_ret = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    cand = (m_ptr + k) % N;
                    if (m_owner < 0 && init_req[cand] && !(was_pend && cand == m_sown))
                        m_owner = cand;
                end
            end
            if (expire) begin
                m_pend = 1'b0;
                m_err  = 1'b1;
            end
            m_age  = was_pend ? m_age + 1 : 0;
            m_prev = split_req;
        end
    end

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_ret)
            g[m_sown] = 1'b1;
        else if (m_owner >= 0)
            g[m_owner] = 1'b1;
        return g;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            logic [N-1:0] g;
            g = model_grant();
            chk("init_grant", int'(init_grant), int'(g));
            chk("split_grant", int'(split_grant), int'(m_ret));
            chk("bus_busy", int'(bus_busy), int'((|g) | m_ret));
            chk("split_pending", int'(split_pending), int'(m_pend));
            chk("split_err", int'(split_err), int'(m_err));
            if (m_pend)
                chk("split_owner", int'(split_owner), m_sown);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r;

        repeat (3) @(posedge clk);
        #1;
        chk("reset grant", int'(init_grant), 0);
        chk("reset busy", int'(bus_busy), 0);
        chk("reset pending", int'(split_pending), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        init_req = 2'b01;

        // Basic grant with one-cycle latency, then release.
        tick();
        chk("basic grant", int'(init_grant), 1);
        chk("basic busy", int'(bus_busy), 1);
        repeat (3) tick();
        init_req = 2'b00;
        tick();
        chk("basic release", int'(init_grant), 0);

        // Fairness: pointer sits at 1 after initiator 0 left.
        init_req = 2'b11;
        tick();
        chk("fair first", int'(init_grant), 2);
        repeat (3) tick();
        init_req = 2'b01;
        tick();
        chk("fair gap1", int'(init_grant), 0);
        init_req = 2'b11;
        tick();
        chk("fair second", int'(init_grant), 1);
        repeat (3) tick();
        init_req = 2'b10;
        tick();
        chk("fair gap2", int'(init_grant), 0);
        init_req = 2'b11;
        tick();
        chk("fair third", int'(init_grant), 2);
        init_req = 2'b01;
        tick();
        chk("fair gap3", int'(init_grant), 0);
        tick();
        chk("fair wrap", int'(init_grant), 1);

        // Split of initiator 0, initiator 1 served meanwhile.
        split_ack = 1'b1;
        tick();
        split_ack = 1'b0;
        chk("split drop", int'(init_grant), 0);
        chk("split pend", int'(split_pending), 1);
        chk("split owner", int'(split_owner), 0);
        init_req = 2'b11;
        tick();
        chk("masked grant", int'(init_grant), 2);
        split_ack = 1'b1;
        tick();
        split_ack = 1'b0;
        chk("second split err", int'(split_err), 1);
        chk("second split grant", int'(init_grant), 0);
        chk("second split owner", int'(split_owner), 0);
        tick();
        chk("err one pulse", int'(split_err), 0);
        chk("regrant masked", int'(init_grant), 2);
        init_req = 2'b01;
        tick();
        chk("release 1", int'(init_grant), 0);
        split_req = 1'b1;
        tick();
        chk("return sgrant", int'(split_grant), 1);
        chk("return grant", int'(init_grant), 1);
        tick();
        chk("return hold", int'(split_grant), 1);
        split_req = 1'b0;
        init_req  = 2'b00;
        tick();
        chk("return end grant", int'(init_grant), 0);
        chk("return end pend", int'(split_pending), 0);

        // Stray split request.
        split_req = 1'b1;
        tick();
        chk("stray err", int'(split_err), 1);
        chk("stray sgrant", int'(split_grant), 0);
        tick();
        chk("stray once", int'(split_err), 0);
        split_req = 1'b0;
        tick();

        // Asynchronous reset in the middle of a split return.
        init_req = 2'b01;
        tick();
        split_ack = 1'b1;
        tick();
        split_ack = 1'b0;
        split_req = 1'b1;
        tick();
        chk("pre-reset return", int'(split_grant), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async grant", int'(init_grant), 0);
        chk("async sgrant", int'(split_grant), 0);
        chk("async pend", int'(split_pending), 0);
        chk("async busy", int'(bus_busy), 0);
        chk("async err", int'(split_err), 0);
        split_req = 1'b0;
        init_req  = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post reset", int'(init_grant), 0);

        // Randomized traffic obeying the bus protocol.
        for (int c = 0; c < 3000; c++) begin
            r = init_req;
            for (int i = 0; i < N; i++) begin
                if (!r[i]) begin
                    if ($urandom_range(2) == 0) r[i] = 1'b1;
                end else if (init_grant[i] && !split_grant && $urandom_range(3) == 0) begin
                    r[i] = 1'b0;
                end
            end
            split_ack = (|init_grant) && !split_grant && ($urandom_range(5) == 0);
            if (!split_req) begin
                if (split_pending && $urandom_range(4) == 0)
                    split_req = 1'b1;
                else if (!split_pending && $urandom_range(40) == 0)
                    split_req = 1'b1;
            end else if (split_grant && $urandom_range(2) == 0) begin
                split_req      = 1'b0;
                r[split_owner] = 1'b0;
            end else if (!split_pending && !split_grant) begin
                split_req = 1'b0;
            end
            init_req = r;
            tick();
        end

        split_ack = 1'b0;
        split_req = 1'b0;
        init_req  = '0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
